// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with valid/ready handshake and illegal counter
module decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter bit          SIGN_EXT_IMM = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2:0]       format_o,
  output logic [6:0]       op_o,
  output logic [2:0]       funct_3_o,
  output logic [6:0]       funct_7_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ERR = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       sext;

  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;

  logic             valid_q, valid_d;
  logic [2:0]       fmt_q, fmt_d;
  logic [6:0]       op_q, op_d;
  logic [2:0]       f3_q, f3_d;
  logic [6:0]       f7_q, f7_d;
  logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;

  assign opc  = instr_i[6:0];
  assign f3   = instr_i[14:12];
  assign f7   = instr_i[31:25];
  assign sext = SIGN_EXT_IMM && instr_i[31];

  // Classify the opcode and apply funct3/funct7 legality rules
  always_comb begin
    dec_fmt = FMT_ERR;
    dec_ill = 1'b0;
    unique case (opc)
      OPC_OP: begin
        dec_fmt = FMT_R;
        if (f7 != 7'b0000000 && f7 != 7'b0100000) dec_ill = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) dec_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_fmt = FMT_I;
        if (f3 == 3'b001 && f7 != 7'b0000000) dec_ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) dec_ill = 1'b1;
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_ill = 1'b1;
      end
      OPC_JALR: begin
        dec_fmt = FMT_I;
        if (f3 != 3'b000) dec_ill = 1'b1;
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        if (f3 >= 3'b011) dec_ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        if (f3 == 3'b010 || f3 == 3'b011) dec_ill = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: dec_fmt = FMT_U;
      OPC_JAL:            dec_fmt = FMT_J;
      default:            dec_fmt = FMT_ERR;
    endcase
    if (dec_fmt == FMT_ERR || instr_i[1:0] != 2'b11) dec_ill = 1'b1;
  end

  // Build register indices and the extended immediate; illegal words carry none
  always_comb begin
    dec_rd  = 5'd0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    dec_imm = '0;
    unique case (dec_fmt)
      FMT_R: begin
        dec_rd  = instr_i[11:7];
        dec_rs1 = instr_i[19:15];
        dec_rs2 = instr_i[24:20];
      end
      FMT_I: begin
        dec_rd        = instr_i[11:7];
        dec_rs1       = instr_i[19:15];
        dec_imm       = {XLEN{sext}};
        dec_imm[11:0] = instr_i[31:20];
      end
      FMT_S: begin
        dec_rs1       = instr_i[19:15];
        dec_rs2       = instr_i[24:20];
        dec_imm       = {XLEN{sext}};
        dec_imm[11:0] = {instr_i[31:25], instr_i[11:7]};
      end
      FMT_B: begin
        dec_rs1       = instr_i[19:15];
        dec_rs2       = instr_i[24:20];
        dec_imm       = {XLEN{sext}};
        dec_imm[12:0] = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      FMT_U: begin
        // U immediates fill the upper word, so they always sign-extend past bit 31
        dec_rd        = instr_i[11:7];
        dec_imm       = {XLEN{instr_i[31]}};
        dec_imm[31:0] = {instr_i[31:12], 12'b0};
      end
      FMT_J: begin
        dec_rd        = instr_i[11:7];
        dec_imm       = {XLEN{sext}};
        dec_imm[20:0] = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      default: ;
    endcase
    if (dec_ill) begin
      dec_rd  = 5'd0;
      dec_rs1 = 5'd0;
      dec_rs2 = 5'd0;
      dec_imm = '0;
    end
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // Next state of the output register: load on accept, drain on handshake, clear on flush
  always_comb begin
    valid_d = valid_q;
    fmt_d   = fmt_q;
    op_d    = op_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      fmt_d   = dec_fmt;
      op_d    = opc;
      f3_d    = f3;
      f7_d    = f7;
      rd_d    = dec_rd;
      rs1_d   = dec_rs1;
      rs2_d   = dec_rs2;
      imm_d   = dec_imm;
      pc_d    = pc_i;
      ill_d   = dec_ill;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
    // A flushed output never completes its handshake, so it is not counted
    if (valid_q && out_ready_i && ill_q && !flush_i && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output register with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      fmt_q   <= 3'd0;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 7'd0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= '0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fmt_q   <= fmt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign format_o      = fmt_q;
  assign op_o          = op_q;
  assign funct_3_o     = f3_q;
  assign funct_7_o     = f7_q;
  assign rd_o          = rd_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign imm_o         = imm_q;
  assign pc_o          = pc_q;
  assign illegal_o     = ill_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [2:0]  format, f3;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, pc_out;
  logic [15:0] cnt;

  logic        z_in_ready, z_out_valid, z_illegal;
  logic [2:0]  z_format, z_f3;
  logic [6:0]  z_op, z_f7;
  logic [4:0]  z_rd, z_rs1, z_rs2;
  logic [31:0] z_imm, z_pc_out;
  logic [1:0]  z_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  decode_stage u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .format_o(format), .op_o(op), .funct_3_o(f3), .funct_7_o(f7),
    .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
    .imm_o(imm), .pc_o(pc_out), .illegal_o(illegal), .illegal_cnt_o(cnt)
  );

  decode_stage #(.XLEN(32), .SIGN_EXT_IMM(1'b0), .CNT_W(2)) u_dut_z (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(z_in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(z_out_valid), .out_ready_i(out_ready),
    .format_o(z_format), .op_o(z_op), .funct_3_o(z_f3), .funct_7_o(z_f7),
    .rd_o(z_rd), .rs1_o(z_rs1), .rs2_o(z_rs2),
    .imm_o(z_imm), .pc_o(z_pc_out), .illegal_o(z_illegal), .illegal_cnt_o(z_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  typedef struct {
    logic [31:0] w;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
    cyc(); cyc();
    check("rst_valid", out_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_cnt", cnt, 0);
    check("rst_imm", imm, 0);
    check("rst_fmt", format, 0);
    rst_n = 1'b1;
    cyc();
    check("rst_in_ready", in_ready, 1);

    // ADDI x1, x2, -1
    in_valid = 1'b1; instr = 32'hFFF1_0093; pc = 32'h0000_1000;
    cyc();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_fmt", format, 1);
    check("addi_rd", rd, 1);
    check("addi_rs1", rs1, 2);
    check("addi_rs2", rs2, 0);
    check("addi_imm_sext", imm, 32'hFFFF_FFFF);
    check("addi_imm_zext", z_imm, 32'h0000_0FFF);
    check("addi_ill", illegal, 0);
    check("addi_pc", pc_out, 32'h0000_1000);

    // BEQ x1, x2, +8
    in_valid = 1'b1; instr = 32'h0020_8463; pc = 32'h0000_1004;
    cyc();
    in_valid = 1'b0;
    check("beq_fmt", format, 3);
    check("beq_rs1", rs1, 1);
    check("beq_rs2", rs2, 2);
    check("beq_rd", rd, 0);
    check("beq_imm", imm, 32'h0000_0008);
    check("beq_imm_zext", z_imm, 32'h0000_0008);
    cyc();
    check("beq_drain", out_valid, 0);

    // Back-pressure: ADD x3,x1,x2 held while ADDI x5,x0,7 waits
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0020_81B3; pc = 32'h0000_2000;
    cyc();
    instr = 32'h0070_0293; pc = 32'h0000_2004;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_rd", rd, 3);
      check("bp_pc", pc_out, 32'h0000_2000);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    cyc();
    check("bp_b_rd", rd, 5);
    check("bp_b_imm", imm, 7);
    check("bp_b_pc", pc_out, 32'h0000_2004);
    instr = 32'h1234_5337; pc = 32'h0000_2008;
    cyc();
    in_valid = 1'b0;
    check("lui_valid", out_valid, 1);
    check("lui_fmt", format, 4);
    check("lui_rd", rd, 6);
    check("lui_imm", imm, 32'h1234_5000);
    cyc();
    check("bp_drain", out_valid, 0);

    // Legality table, streamed back to back
    vecs[0] = '{32'h0000_0000, 3'd6, 1'b1};
    vecs[1] = '{32'h4000_1033, 3'd0, 1'b1};
    vecs[2] = '{32'h4000_0033, 3'd0, 1'b0};
    vecs[3] = '{32'h0000_3003, 3'd1, 1'b1};
    vecs[4] = '{32'h0000_000B, 3'd6, 1'b1};
    vecs[5] = '{32'h0000_2063, 3'd3, 1'b1};
    vecs[6] = '{32'h0000_0013, 3'd1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; instr = vecs[i].w; pc = 32'h0000_3000 + 32'(i * 4);
      cyc();
      check($sformatf("ill_%0d_flag", i), illegal, vecs[i].ill);
      check($sformatf("ill_%0d_fmt", i), format, vecs[i].fmt);
      check($sformatf("ill_%0d_cnt", i), cnt, exp_cnt);
      check($sformatf("ill_%0d_zcnt", i), z_cnt, sat3(exp_cnt));
      if (vecs[i].ill) begin
        check($sformatf("ill_%0d_rd", i), rd, 0);
        exp_cnt++;
      end
    end
    in_valid = 1'b0;
    cyc();
    check("ill_drain", out_valid, 0);
    check("ill_cnt_final", cnt, 5);
    check("ill_zcnt_sat", z_cnt, 3);

    // Flush while an illegal output is held and a new input is valid
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0000_0000;
    cyc();
    check("fl_held", out_valid, 1);
    flush = 1'b1; instr = 32'hFFF1_0093;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid", out_valid, 0);
    check("fl_cnt", cnt, 5);
    cyc();
    check("fl_ignored", out_valid, 0);
    check("fl_cnt2", cnt, 5);

    // Asynchronous reset drops a held output immediately
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0020_81B3;
    cyc();
    in_valid = 1'b0;
    check("ar_held", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_cnt", cnt, 0);
    check("ar_rd", rd, 0);
    rst_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
